// File: rtl/fma16_pkg.sv
// fma16_pkg: types and constants that the fp16 FMA pack stage shares with its
// rounding sub-module.
//   roundmode_t  : 2-bit rounding-mode encoding (RZ, RNE, RD, RU)
//   pack_state_t : pack-stage control states
//   NV/OF/UF/NX  : bit positions inside the 4-bit flags vector
//   BIAS, QNAN, INF, MAXFIN : binary16 encoding constants
package fma16_pkg;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RD  = 2'b10,
    RU  = 2'b11
  } roundmode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } pack_state_t;

  localparam int unsigned NV = 3;
  localparam int unsigned OF = 2;
  localparam int unsigned UF = 1;
  localparam int unsigned NX = 0;

  localparam int          BIAS   = 15;
  localparam logic [15:0] QNAN   = 16'h7E00;
  localparam logic [15:0] INF    = 16'h7C00;
  localparam logic [15:0] MAXFIN = 16'h7BFF;

endpackage

// File: rtl/fma16_round.sv
// fma16_round: combinational rounder and packer for binary16.
//   sign     : result sign
//   exponent : biased exponent of mant[W-1], already >= 1 (normalized/subnormal)
//   mant     : normalized significand, binary point after bit W-1
//   sticky   : OR of bits dropped before this stage
//   rm       : rounding mode
//   result   : packed binary16 value
//   of/uf/nx : overflow, underflow (tiny and inexact), inexact
module fma16_round
  import fma16_pkg::*;
#(
  parameter int unsigned W  = 24,
  parameter int unsigned EW = 8
) (
  input  logic                 sign,
  input  logic signed [EW-1:0] exponent,
  input  logic [W-1:0]         mant,
  input  logic                 sticky,
  input  roundmode_t           rm,
  output logic [15:0]          result,
  output logic                 of,
  output logic                 uf,
  output logic                 nx
);

  localparam logic signed [EW:0] EMAX = (EW+1)'(2*BIAS + 1);

  logic [10:0]        sig;
  logic [10:0]        sig_r;
  logic [11:0]        sum;
  logic               guard, st, inexact, inc, carry, hidden, tiny, away;
  logic signed [EW:0] exp_r;

  always_comb begin
    sig     = mant[W-1 -: 11];
    guard   = mant[W-12];
    st      = (|mant[W-13:0]) | sticky;
    inexact = guard | st;

    if (rm == RNE)      inc = guard & (st | sig[0]);
    else if (rm == RD)  inc = sign & inexact;
    else if (rm == RU)  inc = ~sign & inexact;
    else                inc = 1'b0;

    sum   = {1'b0, sig} + {11'b0, inc};
    carry = sum[11];
    // A carry out leaves 1.0 in the significand and bumps the exponent; a
    // subnormal that rounds up into bit 10 becomes normal with exponent 1.
    sig_r  = carry ? 11'h400 : sum[10:0];
    exp_r  = {exponent[EW-1], exponent} + {{EW{1'b0}}, carry};
    hidden = sig_r[10];
    tiny   = ~mant[W-1];

    away = (rm == RNE) || (rm == RU && !sign) || (rm == RD && sign);
    of   = hidden && (exp_r >= EMAX);

    if (of) begin
      result = (away ? INF : MAXFIN) | {sign, 15'h0};
      nx     = 1'b1;
      uf     = 1'b0;
    end else begin
      result = {sign, (hidden ? exp_r[4:0] : 5'd0), sig_r[9:0]};
      nx     = inexact;
      uf     = tiny & inexact;
    end
  end

endmodule

// File: rtl/fma16_pack.sv
// fma16_pack: back end of the fp16 FMA datapath. Accepts an unrounded
// sign/exponent/significand from the adder stage over valid/ready, normalizes,
// rounds and packs a binary16 result with flags. One operation in flight.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_sign/exp/mant    : unrounded value, exponent of mant[W-1] biased by 15
//   in_sticky           : OR of bits discarded upstream
//   in_zero/inf/nan     : special-result indications
//   in_invalid          : invalid operation occurred
//   roundmode           : 00 RZ, 01 RNE, 10 RD, 11 RU
//   out_valid/out_ready : output handshake; result/flags held while waiting
//   result, flags       : binary16 value, {invalid, overflow, underflow, inexact}
// Build option FMA16_PACK_LZC_EN: normalize in a single cycle using a
// leading-zero count and barrel shift instead of one bit per cycle.
module fma16_pack
  import fma16_pkg::*;
#(
  parameter int unsigned W  = 24,
  parameter int unsigned EW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic signed [EW-1:0] in_exp,
  input  logic [W-1:0]         in_mant,
  input  logic                 in_sticky,
  input  logic                 in_zero,
  input  logic                 in_inf,
  input  logic                 in_nan,
  input  logic                 in_invalid,
  input  logic [1:0]           roundmode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          result,
  output logic [3:0]           flags
);

  localparam logic signed [EW-1:0] ONE_E = EW'(1);

  pack_state_t          state;
  logic                 sign_q, sticky_q, invalid_q;
  logic signed [EW-1:0] exp_q, n_exp;
  logic [W-1:0]         mant_q, n_mant;
  logic                 n_sticky, norm_done;
  roundmode_t           rm_q;
  logic [15:0]          result_q, rnd_result, special_result;
  logic [3:0]           flags_q, rnd_flags, special_flags;
  logic                 rnd_of, rnd_uf, rnd_nx, special;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign result    = result_q;
  assign flags     = flags_q;

  // A zero significand with sticky set is a tiny nonzero value, not a zero.
  always_comb begin
    special        = 1'b1;
    special_result = {in_sign, 15'h0};
    special_flags  = '0;
    special_flags[NV] = in_invalid;
    if (in_nan)
      special_result = QNAN;
    else if (in_inf)
      special_result = INF | {in_sign, 15'h0};
    else if (in_zero || (in_mant == '0 && !in_sticky))
      special_result = {in_sign, 15'h0};
    else
      special = 1'b0;
  end

`ifdef FMA16_PACK_LZC_EN
  // Lands on the same mant/exp/sticky the 1-bit-per-cycle walk would reach:
  // right shift up to exponent 1 (everything to sticky past W bits), or left
  // shift by the leading-zero count limited so the exponent stops at 1.
  int                   e_i, amt, lim, sh, lz;
  logic [W-1:0]         lost_mask;

  always_comb begin
    n_mant    = mant_q;
    n_exp     = exp_q;
    n_sticky  = sticky_q;
    norm_done = 1'b1;
    lost_mask = '0;
    amt       = 0;
    lim       = 0;
    sh        = 0;
    lz        = int'(W);
    e_i       = {{(32-EW){exp_q[EW-1]}}, exp_q};
    for (int unsigned i = 0; i < W; i++)
      if (mant_q[i]) lz = int'(W - 1 - i);
    if (e_i < 1) begin
      amt = 1 - e_i;
      if (amt >= int'(W)) begin
        n_sticky = sticky_q | (|mant_q);
        n_mant   = '0;
      end else begin
        lost_mask = ~({W{1'b1}} << amt);
        n_sticky  = sticky_q | (|(mant_q & lost_mask));
        n_mant    = mant_q >> amt;
      end
      n_exp = ONE_E;
    end else begin
      lim    = e_i - 1;
      sh     = (lz < lim) ? lz : lim;
      n_mant = mant_q << sh;
      n_exp  = exp_q - sh[EW-1:0];
    end
  end
`else
  localparam logic signed [EW-1:0] CAP_E = EW'(1 - int'(W));

  always_comb begin
    n_mant    = mant_q;
    n_exp     = exp_q;
    n_sticky  = sticky_q;
    norm_done = 1'b0;
    if (exp_q < CAP_E) begin
      n_mant   = '0;
      n_sticky = sticky_q | (|mant_q);
      n_exp    = ONE_E;
    end else if (exp_q < ONE_E) begin
      n_mant   = mant_q >> 1;
      n_sticky = sticky_q | mant_q[0];
      n_exp    = exp_q + ONE_E;
    end else if (!mant_q[W-1] && exp_q > ONE_E) begin
      n_mant = mant_q << 1;
      n_exp  = exp_q - ONE_E;
    end else begin
      norm_done = 1'b1;
    end
  end
`endif

  fma16_round #(
    .W  (W),
    .EW (EW)
  ) u_round (
    .sign     (sign_q),
    .exponent (exp_q),
    .mant     (mant_q),
    .sticky   (sticky_q),
    .rm       (rm_q),
    .result   (rnd_result),
    .of       (rnd_of),
    .uf       (rnd_uf),
    .nx       (rnd_nx)
  );

  always_comb begin
    rnd_flags     = '0;
    rnd_flags[NV] = invalid_q;
    rnd_flags[OF] = rnd_of;
    rnd_flags[UF] = rnd_uf;
    rnd_flags[NX] = rnd_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q    <= in_sign;
            exp_q     <= in_exp;
            mant_q    <= in_mant;
            sticky_q  <= in_sticky;
            invalid_q <= in_invalid;
            rm_q      <= roundmode_t'(roundmode);
            if (special) begin
              result_q <= special_result;
              flags_q  <= special_flags;
              state    <= OUT;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          mant_q   <= n_mant;
          exp_q    <= n_exp;
          sticky_q <= n_sticky;
          if (norm_done) state <= ROUND;
        end
        ROUND: begin
          result_q <= rnd_result;
          flags_q  <= rnd_flags;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fma16_pack.sv
module tb_fma16_pack;

`ifdef FMA16_PACK_LZC_EN
  localparam bit LZC = 1'b1;
`else
  localparam bit LZC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic              in_sign;
  logic signed [7:0] in_exp;
  logic [23:0]       in_mant;
  logic              in_sticky, in_zero, in_inf, in_nan, in_invalid;
  logic [1:0]        roundmode;
  logic              out_valid, out_ready;
  logic [15:0]       result;
  logic [3:0]        flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fma16_pack #(
    .W  (24),
    .EW (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_sticky  (in_sticky),
    .in_zero    (in_zero),
    .in_inf     (in_inf),
    .in_nan     (in_nan),
    .in_invalid (in_invalid),
    .roundmode  (roundmode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic s, input int e, input logic [23:0] m, input logic stk,
                       input logic z, input logic inf, input logic nan, input logic inv,
                       input logic [1:0] rm);
    in_sign    = s;
    in_exp     = e[7:0];
    in_mant    = m;
    in_sticky  = stk;
    in_zero    = z;
    in_inf     = inf;
    in_nan     = nan;
    in_invalid = inv;
    roundmode  = rm;
  endtask

  // Issue one operation, measure cycles to out_valid, check, optionally
  // stall the consumer for 'hold' cycles, then complete the handshake.
  task automatic do_op(input string tag, input logic s, input int e, input logic [23:0] m,
                       input logic stk, input logic z, input logic inf, input logic nan,
                       input logic inv, input logic [1:0] rm, input logic [15:0] wres,
                       input logic [3:0] wfl, input int wlat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    drive(s, e, m, stk, z, inf, nan, inv, rm);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " latency"}, lat, wlat);
    chk({tag, " result"}, result, wres);
    chk({tag, " flags"}, flags, wfl);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold out_valid"}, out_valid, 1);
      chk({tag, " hold in_ready"}, in_ready, 0);
      chk({tag, " hold result"}, result, wres);
      chk({tag, " hold flags"}, flags, wfl);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " done out_valid"}, out_valid, 0);
    chk({tag, " done in_ready"}, in_ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 16'h0000);
    chk("reset flags", flags, 4'b0000);

    //      tag          s   exp  mant        stk zero inf nan inv rm     result    flags    latency            hold
    do_op("one",        0,  15, 24'h800000, 0,  0,   0,  0,  0,  2'b01, 16'h3C00, 4'b0000, 3,                 0);
    do_op("leftnorm",   0,  17, 24'h200000, 0,  0,   0,  0,  0,  2'b01, 16'h3C00, 4'b0000, LZC ? 3 : 5,       0);
    do_op("tie_rne",    0,  15, 24'h801000, 0,  0,   0,  0,  0,  2'b01, 16'h3C00, 4'b0001, 3,                 0);
    do_op("tie_ru",     0,  15, 24'h801000, 0,  0,   0,  0,  0,  2'b11, 16'h3C01, 4'b0001, 3,                 5);
    do_op("tie_rd_neg", 1,  15, 24'h801000, 0,  0,   0,  0,  0,  2'b10, 16'hBC01, 4'b0001, 3,                 0);
    do_op("carry",      0,  15, 24'hFFF000, 0,  0,   0,  0,  0,  2'b01, 16'h4000, 4'b0001, 3,                 0);
    do_op("ovf_rne",    0,  31, 24'h800000, 0,  0,   0,  0,  0,  2'b01, 16'h7C00, 4'b0101, 3,                 0);
    do_op("ovf_rz",     0,  31, 24'h800000, 0,  0,   0,  0,  0,  2'b00, 16'h7BFF, 4'b0101, 3,                 0);
    do_op("ovf_rd_neg", 1,  31, 24'h800000, 0,  0,   0,  0,  0,  2'b10, 16'hFC00, 4'b0101, 3,                 0);
    do_op("sub_exp0",   0,   0, 24'h800000, 0,  0,   0,  0,  0,  2'b01, 16'h0200, 4'b0000, LZC ? 3 : 4,       0);
    do_op("sub_m20_ru", 0, -20, 24'h800000, 0,  0,   0,  0,  0,  2'b11, 16'h0001, 4'b0011, LZC ? 3 : 24,      0);
    do_op("sub_cap_ru", 0, -30, 24'h800000, 0,  0,   0,  0,  0,  2'b11, 16'h0001, 4'b0011, LZC ? 3 : 4,       0);
    do_op("sub_to_min", 0,   1, 24'h7FF000, 0,  0,   0,  0,  0,  2'b01, 16'h0400, 4'b0011, 3,                 0);
    do_op("sticky_only",0,   5, 24'h000000, 1,  0,   0,  0,  0,  2'b11, 16'h0001, 4'b0011, LZC ? 3 : 7,       0);
    do_op("nan_inv",    0,  15, 24'h800000, 0,  0,   0,  1,  1,  2'b01, 16'h7E00, 4'b1000, 1,                 0);
    do_op("inf_neg",    1,  15, 24'h800000, 0,  0,   1,  0,  0,  2'b01, 16'hFC00, 4'b0000, 1,                 0);
    do_op("zero_mant",  1,  10, 24'h000000, 0,  0,   0,  0,  0,  2'b11, 16'h8000, 4'b0000, 1,                 0);

    // Reset while the operation sits in NORM.
    @(negedge clk);
    drive(1'b0, -20, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("midop busy in_ready", in_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midop reset in_ready", in_ready, 1);
    chk("midop reset out_valid", out_valid, 0);
    chk("midop reset result", result, 16'h0000);
    chk("midop reset flags", flags, 4'b0000);
    repeat (3) @(negedge clk);
    chk("midop idle out_valid", out_valid, 0);

    do_op("after_reset",0,  15, 24'h800000, 0,  0,   0,  0,  0,  2'b01, 16'h3C00, 4'b0000, 3,                 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
